// File: rtl/signed_or_unsigned_mac.sv
// Two-stage multiply-accumulate: stage P forms the signed/unsigned product, stage A
// accumulates one vector (delimited by last) and presents its sum with overflow/mixed flags.
module signed_or_unsigned_mac #(
   parameter int unsigned n = 8,
   parameter int unsigned m = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [n-1:0]         a,
   input  logic [n-1:0]         b,
   input  logic                 sign,
   input  logic                 last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*n+m-1:0]     out_sum,
   output logic                 out_sign,
   output logic                 out_overflow,
   output logic                 out_mixed
);

   localparam int unsigned PW = 2 * n;
   localparam int unsigned W  = PW + m;

   // Stage P registers
   logic          p_valid_q, p_valid_d;
   logic [PW-1:0] p_prod_q, p_prod_d;
   logic          p_sign_q, p_sign_d;
   logic          p_last_q, p_last_d;

   // Stage A accumulator and per-vector sticky state
   logic [W-1:0]  acc_q, acc_d;
   logic          mode_cap_q, mode_cap_d;
   logic          mode_q, mode_d;
   logic          ovf_q, ovf_d;
   logic          mixed_q, mixed_d;

   // Result registers
   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  out_sum_q, out_sum_d;
   logic          out_sign_q, out_sign_d;
   logic          out_ovf_q, out_ovf_d;
   logic          out_mixed_q, out_mixed_d;

   logic          stall_c;
   logic [PW-1:0] a_ext_c, b_ext_c, prod_c;
   logic          cur_mode_c;
   logic [W-1:0]  ext_c;
   logic [W:0]    sum_full_c;
   logic          step_ovf_c;
   logic          step_mixed_c;

   assign stall_c  = out_valid_q && !out_ready;
   assign in_ready = !stall_c;

   // Low 2n bits of the product of the extended operands equal the true product modulo 2^2n.
   assign a_ext_c = sign ? {{n{a[n-1]}}, a} : {{n{1'b0}}, a};
   assign b_ext_c = sign ? {{n{b[n-1]}}, b} : {{n{1'b0}}, b};
   assign prod_c  = a_ext_c * b_ext_c;

   // First beat of a vector to reach stage A defines the vector mode.
   assign cur_mode_c   = mode_cap_q ? mode_q : p_sign_q;
   assign ext_c        = cur_mode_c ? {{m{p_prod_q[PW-1]}}, p_prod_q} : {{m{1'b0}}, p_prod_q};
   assign sum_full_c   = {1'b0, acc_q} + {1'b0, ext_c};
   assign step_ovf_c   = cur_mode_c
                         ? ((acc_q[W-1] == ext_c[W-1]) && (sum_full_c[W-1] != acc_q[W-1]))
                         : sum_full_c[W];
   assign step_mixed_c = mode_cap_q && (p_sign_q != mode_q);

   always_comb begin
      p_valid_d   = p_valid_q;
      p_prod_d    = p_prod_q;
      p_sign_d    = p_sign_q;
      p_last_d    = p_last_q;
      acc_d       = acc_q;
      mode_cap_d  = mode_cap_q;
      mode_d      = mode_q;
      ovf_d       = ovf_q;
      mixed_d     = mixed_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_sign_d  = out_sign_q;
      out_ovf_d   = out_ovf_q;
      out_mixed_d = out_mixed_q;

      if (!stall_c) begin
         p_valid_d = in_valid;
         if (in_valid) begin
            p_prod_d = prod_c;
            p_sign_d = sign;
            p_last_d = last;
         end

         // Without a stall the current result is either consumed or idle.
         out_valid_d = 1'b0;
         if (p_valid_q) begin
            if (p_last_q) begin
               out_valid_d = 1'b1;
               out_sum_d   = sum_full_c[W-1:0];
               out_sign_d  = cur_mode_c;
               out_ovf_d   = ovf_q | step_ovf_c;
               out_mixed_d = mixed_q | step_mixed_c;
               acc_d       = '0;
               mode_cap_d  = 1'b0;
               mode_d      = 1'b0;
               ovf_d       = 1'b0;
               mixed_d     = 1'b0;
            end else begin
               acc_d       = sum_full_c[W-1:0];
               mode_cap_d  = 1'b1;
               mode_d      = cur_mode_c;
               ovf_d       = ovf_q | step_ovf_c;
               mixed_d     = mixed_q | step_mixed_c;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_valid_q   <= 1'b0;
         p_prod_q    <= '0;
         p_sign_q    <= 1'b0;
         p_last_q    <= 1'b0;
         acc_q       <= '0;
         mode_cap_q  <= 1'b0;
         mode_q      <= 1'b0;
         ovf_q       <= 1'b0;
         mixed_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_sign_q  <= 1'b0;
         out_ovf_q   <= 1'b0;
         out_mixed_q <= 1'b0;
      end else begin
         p_valid_q   <= p_valid_d;
         p_prod_q    <= p_prod_d;
         p_sign_q    <= p_sign_d;
         p_last_q    <= p_last_d;
         acc_q       <= acc_d;
         mode_cap_q  <= mode_cap_d;
         mode_q      <= mode_d;
         ovf_q       <= ovf_d;
         mixed_q     <= mixed_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_sign_q  <= out_sign_d;
         out_ovf_q   <= out_ovf_d;
         out_mixed_q <= out_mixed_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_sum      = out_sum_q;
   assign out_sign     = out_sign_q;
   assign out_overflow = out_ovf_q;
   assign out_mixed    = out_mixed_q;

endmodule

// File: tb/tb_signed_or_unsigned_mac.sv
// Directed bench for signed_or_unsigned_mac at n=4, m=2 (10-bit accumulator).
module tb_signed_or_unsigned_mac;

   localparam int unsigned N = 4;
   localparam int unsigned M = 2;
   localparam int unsigned W = 2 * N + M;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  a;
   logic [N-1:0]  b;
   logic          sign;
   logic          last;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          out_sign;
   logic          out_overflow;
   logic          out_mixed;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [N-1:0] ta;
      logic [N-1:0] tb;
      logic         ts;
      logic         tl;
      logic [W-1:0] exp_sum;
      logic         exp_sign;
      logic         exp_ovf;
      logic         exp_mixed;
   } beat_t;

   beat_t tbl[$];

   signed_or_unsigned_mac #(.n(N), .m(M)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .a            (a),
      .b            (b),
      .sign         (sign),
      .last         (last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sum      (out_sum),
      .out_sign     (out_sign),
      .out_overflow (out_overflow),
      .out_mixed    (out_mixed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic ts,
                      input logic tl, input logic [W-1:0] es, input logic esg,
                      input logic eo, input logic em);
      beat_t r;
      r.ta = ta; r.tb = tb; r.ts = ts; r.tl = tl;
      r.exp_sum = es; r.exp_sign = esg; r.exp_ovf = eo; r.exp_mixed = em;
      tbl.push_back(r);
   endtask

   // Presents one beat at a negedge, waits (bounded) for in_ready, returns after the accepting edge.
   task automatic send_beat(input logic [N-1:0] ta, input logic [N-1:0] tb,
                            input logic ts, input logic tl);
      int k;
      @(negedge clk);
      a = ta; b = tb; sign = ts; last = tl; in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      last     = 1'b0;
   endtask

   task automatic wait_valid(input string nm);
      int k;
      k = 0;
      while (!out_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!out_valid) check(nm, 32'(out_valid), 32'd1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sign = 1'b0; last = 1'b0; out_ready = 1'b1;

      // Unsigned 4 x 15*15 = 900
      for (int i = 0; i < 4; i++) add(4'd15, 4'd15, 1'b0, i == 3, 10'd900, 1'b0, 1'b0, 1'b0);
      // Unsigned 5 x 15*15 = 1125 mod 1024 = 101, overflow
      for (int i = 0; i < 5; i++) add(4'd15, 4'd15, 1'b0, i == 4, 10'd101, 1'b0, 1'b1, 1'b0);
      // Signed (-8)*7 + 3*(-2) = -62
      add(4'h8, 4'h7, 1'b1, 1'b0, 10'h3C2, 1'b1, 1'b0, 1'b0);
      add(4'h3, 4'hE, 1'b1, 1'b1, 10'h3C2, 1'b1, 1'b0, 1'b0);
      // Signed 8 x (-8)*(-8) = 512 wraps to -512, overflow
      for (int i = 0; i < 8; i++) add(4'h8, 4'h8, 1'b1, i == 7, 10'h200, 1'b1, 1'b1, 1'b0);
      // Mixed: signed 1*1 then unsigned 15*1, sign-extended by vector mode
      add(4'd1, 4'd1, 1'b1, 1'b0, 10'd16, 1'b1, 1'b0, 1'b1);
      add(4'd15, 4'd1, 1'b0, 1'b1, 10'd16, 1'b1, 1'b0, 1'b1);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_sum", 32'(out_sum), 32'd0);
      check("rst_flags", {29'd0, out_sign, out_overflow, out_mixed}, 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // Table vectors, each with a latency check on its last beat
      foreach (tbl[i]) begin
         send_beat(tbl[i].ta, tbl[i].tb, tbl[i].ts, tbl[i].tl);
         if (tbl[i].tl) begin
            idle();
            check($sformatf("lat_e1_v%0d", i), 32'(out_valid), 32'd0);
            @(negedge clk);
            check($sformatf("lat_e2_v%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("sum_v%0d", i), 32'(out_sum), 32'(tbl[i].exp_sum));
            check($sformatf("sign_v%0d", i), 32'(out_sign), 32'(tbl[i].exp_sign));
            check($sformatf("ovf_v%0d", i), 32'(out_overflow), 32'(tbl[i].exp_ovf));
            check($sformatf("mixed_v%0d", i), 32'(out_mixed), 32'(tbl[i].exp_mixed));
         end
      end

      // Back-to-back single-beat vectors replace the result without a bubble
      send_beat(4'd1, 4'd1, 1'b0, 1'b1);
      send_beat(4'd2, 4'd2, 1'b0, 1'b1);
      @(negedge clk);
      check("b2b_valid0", 32'(out_valid), 32'd1);
      check("b2b_sum0", 32'(out_sum), 32'd1);
      a = 4'd3; b = 4'd3; sign = 1'b0; last = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; last = 1'b0;
      check("b2b_valid1", 32'(out_valid), 32'd1);
      check("b2b_sum1", 32'(out_sum), 32'd4);
      @(negedge clk);
      check("b2b_valid2", 32'(out_valid), 32'd1);
      check("b2b_sum2", 32'(out_sum), 32'd9);
      @(negedge clk);
      check("b2b_drain", 32'(out_valid), 32'd0);

      // Backpressure: result 6 held for 5 cycles while the next beat waits
      out_ready = 1'b0;
      send_beat(4'd2, 4'd3, 1'b0, 1'b1);
      idle();
      wait_valid("bp_timeout");
      a = 4'd4; b = 4'd4; sign = 1'b0; last = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
         check($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
         check($sformatf("bp_sum_%0d", i), 32'(out_sum), 32'd6);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("bp_consumed", 32'(out_valid), 32'd0);
      a = 4'd5; b = 4'd5; last = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      idle();
      wait_valid("bp_next_timeout");
      check("bp_next_sum", 32'(out_sum), 32'd41);

      // Reset mid-vector discards the pending result and the partial vector
      @(negedge clk);
      out_ready = 1'b0;
      send_beat(4'd1, 4'd5, 1'b0, 1'b1);
      send_beat(4'd7, 4'd7, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      check("pre_rst_sum", 32'(out_sum), 32'd5);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_sum", 32'(out_sum), 32'd0);
      check("mid_rst_flags", {29'd0, out_sign, out_overflow, out_mixed}, 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      send_beat(4'd2, 4'd3, 1'b0, 1'b1);
      idle();
      wait_valid("post_rst_timeout");
      check("post_rst_sum", 32'(out_sum), 32'd6);
      check("post_rst_flags", {29'd0, out_sign, out_overflow, out_mixed}, 32'd0);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
